// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-master I2C write/read engine.
// Each bit period has four phases: SCL is low in P0-P1 and high in P2-P3.
package i2c_pkg;
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ACK_A,
        ST_REG,
        ST_ACK_R,
        ST_WDATA,
        ST_ACK_W,
        ST_RDATA,
        ST_MNACK,
        ST_STOP
    } state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] ID_DEF = 7'b0000101;

    localparam logic [1:0] PH_P0 = 2'd0;
    localparam logic [1:0] PH_P1 = 2'd1;
    localparam logic [1:0] PH_P2 = 2'd2;
    localparam logic [1:0] PH_P3 = 2'd3;
endpackage

// File: rtl/scl_phase_gen.sv
// Quarter-bit timer: counts QTR cycles per phase and steps through P0..P3.
// Held at P0/count 0 while disabled, so every transaction starts phase-aligned.
module scl_phase_gen #(
    parameter int QTR = 31
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    output logic [1:0] o_phase,
    output logic       o_first,
    output logic       o_last,
    output logic       o_pre_last
);
    localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_phase;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_phase <= 2'd0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 2'd0;
        end else if (r_cnt == CW'(QTR - 1)) begin
            r_cnt   <= '0;
            r_phase <= r_phase + 2'd1;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign o_phase    = r_phase;
    assign o_first    = (r_cnt == '0);
    assign o_last     = (r_cnt == CW'(QTR - 1));
    assign o_pre_last = (r_cnt == CW'(QTR - 2));
endmodule

// File: rtl/i2c_master.sv
// I2C master: one register write (ID, reg, data) or register read (ID, reg, then read byte)
// per Start request; open-drain SDA emulated via o_sda_oe with o_sda fixed low.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int         QTR    = 31,
    parameter logic [6:0] ID_DEF = i2c_pkg::ID_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [6:0] i_id,
    input  logic [7:0] i_reg_addr,
    input  logic [7:0] i_wr_data,
    input  logic       i_sda,
    output logic       o_scl,
    output logic       o_sda,
    output logic       o_sda_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_err,
    output logic [7:0] o_rd_data
);
    state_t     r_state, w_state_next;
    logic       r_rw, r_ack_err, r_done;
    logic [6:0] r_id;
    logic [7:0] r_reg, r_wd, r_shift, r_rx, r_rd_data;
    logic [2:0] r_bit_cnt;

    logic [7:0] w_shift_next, w_rx_next, w_rd_next;
    logic [2:0] w_bit_next;
    logic       w_ack_err_next, w_done_next, w_latch;
    logic [1:0] w_phase;
    logic       w_first, w_last, w_pre_last, w_sample, w_bit_end;

    scl_phase_gen #(.QTR(QTR)) u_phase (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (o_busy),
        .o_phase    (w_phase),
        .o_first    (w_first),
        .o_last     (w_last),
        .o_pre_last (w_pre_last)
    );

    assign w_sample  = w_first && (w_phase == PH_P3);
    assign w_bit_end = w_last  && (w_phase == PH_P3);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_rw      <= 1'b0;
            r_id      <= '0;
            r_reg     <= '0;
            r_wd      <= '0;
            r_shift   <= '0;
            r_rx      <= '0;
            r_rd_data <= '0;
            r_bit_cnt <= '0;
            r_ack_err <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_rx      <= w_rx_next;
            r_rd_data <= w_rd_next;
            r_bit_cnt <= w_bit_next;
            r_ack_err <= w_ack_err_next;
            r_done    <= w_done_next;
            if (w_latch) begin
                r_rw  <= i_rw;
                r_id  <= (i_id == 7'd0) ? ID_DEF : i_id;
                r_reg <= i_reg_addr;
                r_wd  <= i_wr_data;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_rx_next      = r_rx;
        w_rd_next      = r_rd_data;
        w_bit_next     = r_bit_cnt;
        w_ack_err_next = r_ack_err;
        w_done_next    = 1'b0;
        w_latch        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next   = ST_START;
                    w_latch        = 1'b1;
                    w_ack_err_next = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next = ST_ADDR;
                    w_shift_next = {r_id, r_rw};
                    w_bit_next   = 3'd0;
                end
            end
            ST_ADDR, ST_REG, ST_WDATA: begin
                if (w_bit_end) begin
                    w_shift_next = {r_shift[6:0], 1'b0};
                    w_bit_next   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = (r_state == ST_ADDR) ? ST_ACK_A :
                                       (r_state == ST_REG)  ? ST_ACK_R : ST_ACK_W;
                    end
                end
            end
            ST_ACK_A, ST_ACK_R, ST_ACK_W: begin
                if (w_sample && (i_sda == NACK)) begin
                    w_ack_err_next = 1'b1;
                end
                // r_ack_err was updated at the P3 sample, well before the bit ends
                if (w_bit_end) begin
                    if (r_ack_err || (r_state == ST_ACK_W)) begin
                        w_state_next = ST_STOP;
                    end else if (r_state == ST_ACK_A) begin
                        w_state_next = ST_REG;
                        w_shift_next = r_reg;
                    end else begin
                        w_state_next = r_rw ? ST_RDATA : ST_WDATA;
                        w_shift_next = r_wd;
                    end
                end
            end
            ST_RDATA: begin
                if (w_sample) begin
                    w_rx_next = {r_rx[6:0], i_sda};
                end
                if (w_bit_end) begin
                    w_bit_next = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = ST_MNACK;
                    end
                end
            end
            ST_MNACK: begin
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave one cycle early: the Done cycle is idle, and idle bus levels match STOP P3
                if (w_pre_last && (w_phase == PH_P3)) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                    if (r_rw && !r_ack_err) begin
                        w_rd_next = r_rx;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_scl    = w_phase[1];
        o_sda_oe = 1'b0;
        unique case (r_state)
            ST_IDLE:                   o_scl = 1'b1;
            ST_START: begin
                o_scl    = 1'b1;
                o_sda_oe = w_phase[1];
            end
            ST_ADDR, ST_REG, ST_WDATA: o_sda_oe = ~r_shift[7];
            ST_STOP:                   o_sda_oe = (w_phase != PH_P3);
            default:                   o_sda_oe = 1'b0;
        endcase
    end

    assign o_sda     = 1'b0;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_done    = r_done;
    assign o_ack_err = r_ack_err;
    assign o_rd_data = r_rd_data;
endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master at QTR=4: a cycle-accurate slave drives ACKs and read data,
// and the SDA level in the middle of each SCL-high phase is collected per bit period.
module tb_i2c_master;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       rw;
    logic [6:0] id;
    logic [7:0] ra, wd;
    logic       slave_low;
    logic       sda_line;
    logic       scl, sda_o, sda_oe, busy, done, ack_err;
    logic [7:0] rd_data;

    int n_chk  = 0;
    int n_pass = 0;

    assign sda_line = ~(sda_oe | slave_low);

    always #5 clk = ~clk;

    i2c_master #(.QTR(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_rw       (rw),
        .i_id       (id),
        .i_reg_addr (ra),
        .i_wr_data  (wd),
        .i_sda      (sda_line),
        .o_scl      (scl),
        .o_sda      (sda_o),
        .o_sda_oe   (sda_oe),
        .o_busy     (busy),
        .o_done     (done),
        .o_ack_err  (ack_err),
        .o_rd_data  (rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Runs one transaction; bit period k occupies offsets 16k+1..16k+16 after the accept edge.
    task automatic run_txn(input string name, input logic t_rw, input logic [6:0] t_id,
                           input logic [7:0] t_ra, input logic [7:0] t_wd,
                           input logic [7:0] slave_byte, input logic nack_a,
                           input bit skip_start, input int pulse_at, input bit b2b,
                           input int abort_at, input int nbits, input logic [28:0] exp_seen,
                           input int exp_done, input logic exp_ack, input logic [7:0] exp_rd);
        logic [28:0] seen;
        int          k;
        int          done_at;
        int          done_cnt;
        logic        busy1, scl1, sda1, scl17, scl25, busy_done;
        seen      = '0;
        done_at   = 0;
        done_cnt  = 0;
        busy1     = 1'b0;
        scl1      = 1'b0;
        sda1      = 1'b0;
        scl17     = 1'b1;
        scl25     = 1'b0;
        busy_done = 1'b1;
        if (!skip_start) begin
            @(negedge clk);
            rw = t_rw; id = t_id; ra = t_ra; wd = t_wd;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int j = 1; j <= exp_done + 4; j++) begin
            k = (j - 1) / 16;
            slave_low = 1'b0;
            if (k == 9 && !nack_a) slave_low = 1'b1;
            if (k == 18 || (k == 27 && !t_rw)) slave_low = 1'b1;
            if (t_rw && k >= 19 && k <= 26) slave_low = ~slave_byte[26 - k];
            if (j == pulse_at) begin
                start = 1'b1; rw = ~t_rw; id = 7'h7F; ra = ~t_ra; wd = ~t_wd;
            end
            if (j == pulse_at + 1) begin
                start = 1'b0; rw = t_rw; id = t_id; ra = t_ra; wd = t_wd;
            end
            @(negedge clk);
            if (j == 1) begin busy1 = busy; scl1 = scl; sda1 = sda_line; end
            if (j == 17) scl17 = scl;
            if (j == 25) scl25 = scl;
            if ((j - 1) % 16 == 9 && k < 29) seen[28 - k] = sda_line;
            if (done) begin
                done_cnt++;
                if (done_at == 0) begin done_at = j; busy_done = busy; end
            end
            if (j == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check({name, " rst scl"}, scl, 1'b1);
                check({name, " rst oe"}, sda_oe, 1'b0);
                check({name, " rst busy"}, busy, 1'b0);
                check({name, " rst ackerr"}, ack_err, 1'b0);
                check({name, " rst rd"}, rd_data, 8'h00);
                slave_low = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check({name, " rst held idle"}, {busy, scl, sda_oe}, 3'b010);
                rst_n = 1'b1;
                $display("txn %s: reset applied at offset %0d", name, j);
                return;
            end
            if (b2b && done) begin
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        slave_low = 1'b0;
        check({name, " serial"}, 32'(seen >> (29 - nbits)), 32'(exp_seen >> (29 - nbits)));
        check({name, " done at"}, done_at, exp_done);
        check({name, " done pulses"}, done_cnt, 1);
        check({name, " busy in done"}, busy_done, 1'b0);
        check({name, " busy first"}, busy1, 1'b1);
        check({name, " start P0 levels"}, {scl1, sda1}, 2'b11);
        check({name, " scl low P0"}, scl17, 1'b0);
        check({name, " scl high P2"}, scl25, 1'b1);
        check({name, " ack_err"}, ack_err, exp_ack);
        check({name, " rd_data"}, rd_data, exp_rd);
        $display("txn %s: done_at=%0d ack_err=%0b rd_data=%02h", name, done_at, ack_err, rd_data);
    endtask

    localparam logic [28:0] EXP_WR  = 29'b0_00001010_0_10100101_0_01010010_0_0;
    localparam logic [28:0] EXP_RD  = 29'b0_00001011_0_10110101_0_00111100_1_0;
    localparam logic [28:0] EXP_ERR = {11'b0_10101011_1_0, 18'd0};
    localparam logic [28:0] EXP_WR2 = 29'b0_00001010_0_00111100_0_11000011_0_0;

    initial begin
        rst_n = 1'b0; start = 1'b0; rw = 1'b0; id = '0; ra = '0; wd = '0; slave_low = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset scl", scl, 1'b1);
        check("reset oe/osda", {sda_oe, sda_o}, 2'b00);
        check("reset busy/done", {busy, done}, 2'b00);
        check("reset ackerr/rd", {ack_err, rd_data}, 9'h000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn("write", 1'b0, 7'h05, 8'hA5, 8'h52, 8'h00, 1'b0, 1'b0, 0, 1'b0, 0,
                29, EXP_WR, 464, 1'b0, 8'h00);
        run_txn("read", 1'b1, 7'h05, 8'hB5, 8'h00, 8'h3C, 1'b0, 1'b0, 0, 1'b0, 0,
                29, EXP_RD, 464, 1'b0, 8'h3C);
        run_txn("nack_addr", 1'b1, 7'h55, 8'h12, 8'h00, 8'hF0, 1'b1, 1'b0, 0, 1'b0, 0,
                11, EXP_ERR, 176, 1'b1, 8'h3C);
        run_txn("ignore_start", 1'b0, 7'h05, 8'hA5, 8'h52, 8'h00, 1'b0, 1'b0, 100, 1'b1, 0,
                29, EXP_WR, 464, 1'b0, 8'h3C);
        run_txn("back_to_back", 1'b0, 7'h05, 8'hA5, 8'h52, 8'h00, 1'b0, 1'b1, 0, 1'b0, 0,
                29, EXP_WR, 464, 1'b0, 8'h3C);
        run_txn("abort", 1'b0, 7'h05, 8'hA5, 8'h52, 8'h00, 1'b0, 1'b0, 0, 1'b0, 214,
                29, EXP_WR, 464, 1'b0, 8'h00);
        run_txn("after_reset", 1'b0, 7'h05, 8'h3C, 8'hC3, 8'h00, 1'b0, 1'b0, 0, 1'b0, 0,
                29, EXP_WR2, 464, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end
endmodule
